// File: rtl/seq_bin_to_bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// Holds the FSM state codes, the add-3 correction values and the digit sizing helper.
// No logic here; imported by the converter files.
package seq_bcd_pkg;

  // FSM state encoding; the spare code 2'd2/2'd3 falls back to idle
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;

  // A BCD digit at or above this value would overflow past 9 when doubled
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Number of decimal digits needed to hold 2^width-1. The digit count of
  // 2^width-1 equals ceil(width*log10(2)) since 2^width is never a power of 10.
  function automatic int min_digits(input int width);
    logic [63:0] v;
    int          n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        n = n + 1;
        v = v / 64'd10;
      end
    end
    if (n < 1) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/seq_bin_to_bcd_if.sv
// Request/result bundle between a controller and the BCD converter.
// The controller drives start/bin and picks up busy/done/bcd.
// Handshake is start/busy/done; no queuing, start is ignored while busy.
interface seq_bin_to_bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/seq_bin_to_bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
// Purely combinational, zero latency.
// No flow control; the 4-bit sum wraps with no carry to the next digit.
module bcd_digit_adjust
  import seq_bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADJ_THRESH) ? (din + ADJ_ADD) : din;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Latency: done pulses WIDTH cycles after start is accepted; one conversion per WIDTH+1 cycles.
// start is only sampled in idle; requests while busy are dropped, bcd holds the last result.
module seq_bin_to_bcd
  import seq_bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
)(
  input  logic           clk,
  input  logic           reset,
  seq_bin_to_bcd_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  // Reject parameter combinations that cannot hold the full operand range
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("seq_bin_to_bcd: WIDTH must be in 4..32");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("seq_bin_to_bcd: DIGITS too small for WIDTH");
  end

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    scratch_nxt;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bcd_q;
  logic             done_q;

  logic             accept;
  logic             last;
  logic             shifting;
  logic             unused_adj_top;

  // Per-digit add-3 correction ahead of every shift
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (scratch[4*d +: 4]),
      .dout (adj[4*d +: 4])
    );
  end

  // The top bit of the adjusted value is shifted out; it is always 0 for legal DIGITS
  assign unused_adj_top = adj[BW-1];
  assign scratch_nxt    = {adj[BW-2:0], shreg[WIDTH-1]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: launch on start, return to idle after the last bit
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = bus.start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_nxt = (cnt == CW'(1)) ? ST_IDLE : ST_SHIFT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output/control decode from the current state
  always_comb begin
    accept   = 1'b0;
    last     = 1'b0;
    shifting = 1'b0;
    case (state)
      ST_IDLE:  accept = bus.start;
      ST_SHIFT: begin
        shifting = 1'b1;
        last     = (cnt == CW'(1));
      end
      default: ;
    endcase
  end

  // Datapath: load operand, adjust-and-shift each cycle, publish result on the last bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        shreg   <= bus.bin;
        scratch <= '0;
        cnt     <= CW'(WIDTH);
      end else if (shifting) begin
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        scratch <= scratch_nxt;
        cnt     <= cnt - CW'(1);
        if (last) bcd_q <= scratch_nxt;
      end
    end
  end

  assign bus.busy = shifting;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Self-checking bench for seq_bin_to_bcd: a 16-bit/5-digit and an 8-bit/3-digit instance.
// Results are compared against a decimal model built with plain % and / arithmetic.
// Covers latency, held results, ignored starts, done-cycle restart and mid-run reset.
module tb_seq_bin_to_bcd;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  seq_bin_to_bcd_if #(.WIDTH(16), .DIGITS(5)) if16 ();
  seq_bin_to_bcd_if #(.WIDTH(8),  .DIGITS(3)) if8  ();

  seq_bin_to_bcd #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (if16)
  );

  seq_bin_to_bcd #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: peel digits off with modulo/divide
  function automatic logic [63:0] to_bcd(input int unsigned v);
    logic [63:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < 16; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One 16-bit conversion: measure latency, confirm busy held, check result and single-cycle done
  task automatic convert16(input logic [15:0] val);
    int lat;
    bit busy_ok;
    @(negedge clk);
    if16.start = 1'b1;
    if16.bin   = val;
    @(negedge clk);
    if16.start = 1'b0;
    if16.bin   = 16'hFFFF;
    lat = 0;
    busy_ok = 1'b1;
    while (!if16.done && lat < 40) begin
      if (!if16.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("lat16", 64'(lat), 64'd16);
    chk("busy16_held", 64'(busy_ok), 64'd1);
    chk("bcd16", 64'(if16.bcd), to_bcd(32'(val)));
    chk("busy16_after", 64'(if16.busy), 64'd0);
    @(negedge clk);
    chk("done16_pulse", 64'(if16.done), 64'd0);
    chk("bcd16_hold", 64'(if16.bcd), to_bcd(32'(val)));
  endtask

  task automatic convert8(input logic [7:0] val);
    int lat;
    @(negedge clk);
    if8.start = 1'b1;
    if8.bin   = val;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 0;
    while (!if8.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("lat8", 64'(lat), 64'd8);
    chk("bcd8", 64'(if8.bcd), to_bcd(32'(val)));
  endtask

  initial begin
    int ndone;
    int first;
    logic [63:0] seen;
    bit hold_ok;
    bit quiet_ok;
    int gap;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    if16.start = 1'b0;
    if16.bin   = '0;
    if8.start  = 1'b0;
    if8.bin    = '0;

    #3 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy16", 64'(if16.busy), 64'd0);
    chk("rst_done16", 64'(if16.done), 64'd0);
    chk("rst_bcd16",  64'(if16.bcd),  64'd0);
    chk("rst_busy8",  64'(if8.busy),  64'd0);
    chk("rst_bcd8",   64'(if8.bcd),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed corner values, then random operands
    convert16(16'd0);
    convert16(16'd65535);
    convert16(16'd1234);
    for (int i = 0; i < 20; i++) convert16(16'($urandom_range(0, 65535)));

    // Start while busy must be ignored
    @(negedge clk);
    if16.start = 1'b1;
    if16.bin   = 16'd4321;
    @(negedge clk);
    ndone = 0;
    first = -1;
    seen  = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        if16.start = 1'b1;
        if16.bin   = 16'd9999;
      end else begin
        if16.start = 1'b0;
      end
      @(negedge clk);
      if (if16.done) begin
        ndone++;
        if (first < 0) begin
          first = c;
          seen  = 64'(if16.bcd);
        end
      end
    end
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_lat", 64'(first), 64'd16);
    chk("ign_bcd", seen, to_bcd(4321));

    // Restart in the done cycle
    @(negedge clk);
    if16.start = 1'b1;
    if16.bin   = 16'd100;
    @(negedge clk);
    if16.start = 1'b0;
    for (int c = 0; c < 40 && !if16.done; c++) @(negedge clk);
    chk("dc_bcd_first", 64'(if16.bcd), to_bcd(100));
    if16.start = 1'b1;
    if16.bin   = 16'd42;
    @(negedge clk);
    if16.start = 1'b0;
    if16.bin   = 16'd0;
    chk("dc_done_drop", 64'(if16.done), 64'd0);
    gap = 1;
    hold_ok = 1'b1;
    while (!if16.done && gap < 40) begin
      if (if16.bcd !== to_bcd(100)) hold_ok = 1'b0;
      @(negedge clk);
      gap++;
    end
    chk("dc_hold", 64'(hold_ok), 64'd1);
    chk("dc_gap", 64'(gap), 64'd17);
    chk("dc_bcd_second", 64'(if16.bcd), to_bcd(42));

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    if16.start = 1'b1;
    if16.bin   = 16'd31337;
    @(negedge clk);
    if16.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy_pre", 64'(if16.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_busy", 64'(if16.busy), 64'd0);
    chk("mid_done", 64'(if16.done), 64'd0);
    chk("mid_bcd",  64'(if16.bcd),  64'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet_ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (if16.done || if16.busy) quiet_ok = 1'b0;
    end
    chk("mid_quiet", 64'(quiet_ok), 64'd1);
    convert16(16'd7);

    // Exhaustive sweep of the 8-bit instance
    for (int v = 0; v < 256; v++) convert8(8'(v));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_bin_to_bcd.md
Name: seq_bin_to_bcd

Overview:
Sequential shift-add-3 (double-dabble) binary-to-BCD converter. It takes an unsigned binary word, such as a multiplier product or a counter value, and produces packed BCD digits for the per-digit BCD/hex seven-segment decoders downstream. It uses one iteration per input bit, so it replaces the large combinational divide/modulo chain with roughly WIDTH cycles of latency. A start/busy/done handshake lets a controller launch conversions and pick up results.

Parameters:
WIDTH, 16, input binary width in bits (legal range 4..32).
DIGITS, 5, number of BCD output digits. Must satisfy DIGITS >= ceil(WIDTH*log10(2)); otherwise elaboration fails via a generate-time error.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  conversion request; sampled only in IDLE.
bin  input  WIDTH  unsigned binary operand; sampled on the edge that accepts start.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse; bcd holds a new valid result.
bcd  output  4*DIGITS  packed result; digit k occupies bits [4k+3:4k], with digit 0 as the least significant.

Behaviour:
- Interface: one clock (clk), asynchronous active-high reset (reset).
- Reset (async assert, any state): state=IDLE, busy=0, done=0, bcd=0, internal shift/scratch/counter registers=0.
- States: IDLE, SHIFT. Two-bit encoding from the package; the unused code returns to IDLE.
- IDLE:
  - With start=1 at an edge: latch bin into the shift register, clear the BCD scratch register, load cnt=WIDTH, go to SHIFT, set busy=1.
  - With start=0: remain in IDLE.
  - done=0 on every edge except the completion edge.
- SHIFT, each edge:
  - Every scratch digit >=5 gets +3 (4-bit add, no carry-out between digits).
  - Then {scratch, shift} shifts left by 1, taking the shift MSB into scratch bit 0.
  - cnt decrements.
- Completion edge (the edge where cnt==1):
  - Write the final adjusted-and-shifted scratch value to bcd.
  - done<=1, busy<=0, state<=IDLE.
- Latency: start sampled at edge E0; done=1 and bcd valid in the cycle following edge E_WIDTH, i.e. exactly WIDTH cycles after acceptance. Throughput is one conversion per WIDTH+1 cycles with back-to-back starts.
- bcd holds its last result until the next completion edge; it never shows intermediate values.
- start while busy=1 is ignored; no queuing, and bin changes are ignored.
- start=1 in the done cycle (state is IDLE) is accepted: the new conversion starts and done drops next cycle.
- Operand 0 gives bcd=0 with done after WIDTH cycles; there is no early exit.
- Maximum operand 2^WIDTH-1 must convert exactly; scratch digits never exceed 9 after adjust-and-shift.
- Reset mid-SHIFT aborts the conversion: no done pulse, and bcd is cleared to 0.
- Zero-extend the scratch register to 4*DIGITS; the upper digits simply remain 0.

Decomposition:
- Package seq_bcd_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1.
  - ADJ_THRESH=4'd5 and ADJ_ADD=4'd3.
  - Function computing the minimum legal DIGITS for a WIDTH.
- Sub-module bcd_digit_adjust: combinational 4-bit in, 4-bit out (in>=5 ? in+3 : in). It is instantiated DIGITS times in a generate loop.
- The counter width is $clog2(WIDTH+1).

Test Plan:
- WIDTH=16: reset, then start with bin=16'd0 -> busy high for 16 cycles; done pulse exactly 16 cycles after acceptance; bcd=20'h00000.
- bin=16'd65535 -> bcd=20'h65535 (digits 6,5,5,3,5); bin=16'd1234 -> bcd=20'h01234; done is a single cycle each time.
- Start at E0 with bin=16'd4321, then start=1 with bin=16'd9999 at E5 -> second request ignored; result 20'h04321; exactly one done pulse.
- Start asserted in the done cycle with bin=16'd42 after a 16'd100 conversion -> bcd=20'h00100 held 16 cycles, then 20'h00042; done pulses spaced 17 cycles apart.
- Reset asserted asynchronously at mid-conversion cycle 7 (between edges) -> busy, done and bcd drop to 0 immediately; no done pulse afterwards; next start with 16'd7 gives 20'h00007.
- WIDTH=8, DIGITS=3 instance: exhaustive sweep of 0..255 compared against a decimal model; done latency of 8 cycles every time.
